// File: rtl/mul_ex_pipeline.sv
// Five-stage pipelined integer multiply unit (EX1..EX5) returning the low DATA_WIDTH bits of rs1*rs2.
// The product is built from half-width partial products so no stage holds a full-width multiplier.
module mul_ex_pipeline #(
   parameter int DATA_WIDTH     = 32,
   parameter int REGISTER_WIDTH = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      dec_valid_i,
   input  logic                      dec_is_mul_i,
   input  logic [DATA_WIDTH-1:0]     dec_rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     dec_rs2_data_i,
   input  logic [REGISTER_WIDTH-1:0] dec_wr_reg_i,
   input  logic                      ex_bubble_i,
   input  logic                      stall_ex_i,
   output logic                      ex1_valid_o,
   output logic                      ex2_valid_o,
   output logic                      ex3_valid_o,
   output logic                      ex4_valid_o,
   output logic                      ex5_valid_o,
   output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
   output logic [DATA_WIDTH-1:0]     ex5_result_o,
   output logic                      ex5_wr_en_o,
   output logic                      wb_is_next_cycle_o
);

   localparam int H = DATA_WIDTH / 2;

   logic                      ex1_valid_q, ex1_valid_d;
   logic                      ex2_valid_q, ex2_valid_d;
   logic                      ex3_valid_q, ex3_valid_d;
   logic                      ex4_valid_q, ex4_valid_d;
   logic                      ex5_valid_q, ex5_valid_d;
   logic [REGISTER_WIDTH-1:0] ex1_wr_reg_q, ex1_wr_reg_d;
   logic [REGISTER_WIDTH-1:0] ex2_wr_reg_q, ex2_wr_reg_d;
   logic [REGISTER_WIDTH-1:0] ex3_wr_reg_q, ex3_wr_reg_d;
   logic [REGISTER_WIDTH-1:0] ex4_wr_reg_q, ex4_wr_reg_d;
   logic [REGISTER_WIDTH-1:0] ex5_wr_reg_q, ex5_wr_reg_d;
   logic [DATA_WIDTH-1:0]     ex1_rs1_q, ex1_rs1_d;
   logic [DATA_WIDTH-1:0]     ex1_rs2_q, ex1_rs2_d;
   logic [DATA_WIDTH-1:0]     ex2_lolo_q, ex2_lolo_d;
   logic [H-1:0]              ex2_lohi_q, ex2_lohi_d;
   logic [H-1:0]              ex2_hilo_q, ex2_hilo_d;
   logic [DATA_WIDTH-1:0]     ex3_lolo_q, ex3_lolo_d;
   logic [H-1:0]              ex3_cross_q, ex3_cross_d;
   logic [DATA_WIDTH-1:0]     ex4_prod_q, ex4_prod_d;
   logic [DATA_WIDTH-1:0]     ex5_prod_q, ex5_prod_d;

   logic                      accept_s;
   logic [DATA_WIDTH-1:0]     a_lo_ext_s, b_lo_ext_s;
   logic [H-1:0]              a_lo_s, a_hi_s, b_lo_s, b_hi_s;

   assign accept_s   = dec_valid_i & dec_is_mul_i & ~ex_bubble_i;
   assign a_lo_s     = ex1_rs1_q[H-1:0];
   assign a_hi_s     = ex1_rs1_q[DATA_WIDTH-1:H];
   assign b_lo_s     = ex1_rs2_q[H-1:0];
   assign b_hi_s     = ex1_rs2_q[DATA_WIDTH-1:H];
   // Zero-extend the low halves so lo*lo keeps its full 2H-bit product.
   assign a_lo_ext_s = {{H{1'b0}}, a_lo_s};
   assign b_lo_ext_s = {{H{1'b0}}, b_lo_s};

   // Next-state: advance every stage unless the hazard unit freezes EX.
   always_comb begin
      ex1_valid_d  = ex1_valid_q;
      ex2_valid_d  = ex2_valid_q;
      ex3_valid_d  = ex3_valid_q;
      ex4_valid_d  = ex4_valid_q;
      ex5_valid_d  = ex5_valid_q;
      ex1_wr_reg_d = ex1_wr_reg_q;
      ex2_wr_reg_d = ex2_wr_reg_q;
      ex3_wr_reg_d = ex3_wr_reg_q;
      ex4_wr_reg_d = ex4_wr_reg_q;
      ex5_wr_reg_d = ex5_wr_reg_q;
      ex1_rs1_d    = ex1_rs1_q;
      ex1_rs2_d    = ex1_rs2_q;
      ex2_lolo_d   = ex2_lolo_q;
      ex2_lohi_d   = ex2_lohi_q;
      ex2_hilo_d   = ex2_hilo_q;
      ex3_lolo_d   = ex3_lolo_q;
      ex3_cross_d  = ex3_cross_q;
      ex4_prod_d   = ex4_prod_q;
      ex5_prod_d   = ex5_prod_q;
      if (!stall_ex_i) begin
         ex1_valid_d = accept_s;
         if (accept_s) begin
            ex1_wr_reg_d = dec_wr_reg_i;
            ex1_rs1_d    = dec_rs1_data_i;
            ex1_rs2_d    = dec_rs2_data_i;
         end else begin
            ex1_wr_reg_d = ex1_wr_reg_q;
            ex1_rs1_d    = ex1_rs1_q;
            ex1_rs2_d    = ex1_rs2_q;
         end
         ex2_valid_d  = ex1_valid_q;
         ex2_wr_reg_d = ex1_wr_reg_q;
         ex2_lolo_d   = a_lo_ext_s * b_lo_ext_s;
         ex2_lohi_d   = a_lo_s * b_hi_s;
         ex2_hilo_d   = a_hi_s * b_lo_s;
         ex3_valid_d  = ex2_valid_q;
         ex3_wr_reg_d = ex2_wr_reg_q;
         ex3_lolo_d   = ex2_lolo_q;
         ex3_cross_d  = ex2_lohi_q + ex2_hilo_q;
         ex4_valid_d  = ex3_valid_q;
         ex4_wr_reg_d = ex3_wr_reg_q;
         ex4_prod_d   = ex3_lolo_q + {ex3_cross_q, {H{1'b0}}};
         ex5_valid_d  = ex4_valid_q;
         ex5_wr_reg_d = ex4_wr_reg_q;
         ex5_prod_d   = ex4_prod_q;
      end else begin
         ex1_valid_d = ex1_valid_q;
      end
   end

   // Pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ex1_valid_q  <= 1'b0;
         ex2_valid_q  <= 1'b0;
         ex3_valid_q  <= 1'b0;
         ex4_valid_q  <= 1'b0;
         ex5_valid_q  <= 1'b0;
         ex1_wr_reg_q <= '0;
         ex2_wr_reg_q <= '0;
         ex3_wr_reg_q <= '0;
         ex4_wr_reg_q <= '0;
         ex5_wr_reg_q <= '0;
         ex1_rs1_q    <= '0;
         ex1_rs2_q    <= '0;
         ex2_lolo_q   <= '0;
         ex2_lohi_q   <= '0;
         ex2_hilo_q   <= '0;
         ex3_lolo_q   <= '0;
         ex3_cross_q  <= '0;
         ex4_prod_q   <= '0;
         ex5_prod_q   <= '0;
      end else begin
         ex1_valid_q  <= ex1_valid_d;
         ex2_valid_q  <= ex2_valid_d;
         ex3_valid_q  <= ex3_valid_d;
         ex4_valid_q  <= ex4_valid_d;
         ex5_valid_q  <= ex5_valid_d;
         ex1_wr_reg_q <= ex1_wr_reg_d;
         ex2_wr_reg_q <= ex2_wr_reg_d;
         ex3_wr_reg_q <= ex3_wr_reg_d;
         ex4_wr_reg_q <= ex4_wr_reg_d;
         ex5_wr_reg_q <= ex5_wr_reg_d;
         ex1_rs1_q    <= ex1_rs1_d;
         ex1_rs2_q    <= ex1_rs2_d;
         ex2_lolo_q   <= ex2_lolo_d;
         ex2_lohi_q   <= ex2_lohi_d;
         ex2_hilo_q   <= ex2_hilo_d;
         ex3_lolo_q   <= ex3_lolo_d;
         ex3_cross_q  <= ex3_cross_d;
         ex4_prod_q   <= ex4_prod_d;
         ex5_prod_q   <= ex5_prod_d;
      end
   end

   assign ex1_valid_o        = ex1_valid_q;
   assign ex2_valid_o        = ex2_valid_q;
   assign ex3_valid_o        = ex3_valid_q;
   assign ex4_valid_o        = ex4_valid_q;
   assign ex5_valid_o        = ex5_valid_q;
   assign ex1_wr_reg_o       = ex1_wr_reg_q;
   assign ex2_wr_reg_o       = ex2_wr_reg_q;
   assign ex3_wr_reg_o       = ex3_wr_reg_q;
   assign ex4_wr_reg_o       = ex4_wr_reg_q;
   assign ex5_wr_reg_o       = ex5_wr_reg_q;
   assign ex5_result_o       = ex5_prod_q;
   assign ex5_wr_en_o        = ex5_valid_q & (ex5_wr_reg_q != {REGISTER_WIDTH{1'b0}});
   assign wb_is_next_cycle_o = ex4_valid_q & ~stall_ex_i;

endmodule

// File: tb/tb_mul_ex_pipeline.sv
// Self-checking bench for mul_ex_pipeline: directed cases plus randomized traffic
// compared every cycle against a slot model that forms the full product directly.
module tb_mul_ex_pipeline;

   logic        clk_i = 1'b0;
   logic        rst_ni, dec_valid_i, dec_is_mul_i, ex_bubble_i, stall_ex_i;
   logic [31:0] dec_rs1_data_i, dec_rs2_data_i;
   logic [4:0]  dec_wr_reg_i;
   logic        ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
   logic [4:0]  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o;
   logic [31:0] ex5_result_o;
   logic        ex5_wr_en_o, wb_is_next_cycle_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Model: slot k = EX(k+1); operands held in EX1 so bubbles carry data forward.
   logic        m_v [5];
   logic [4:0]  m_w [5];
   logic [31:0] m_p [5];
   logic [31:0] m_a, m_b;

   always #5 clk_i = ~clk_i;

   mul_ex_pipeline #(.DATA_WIDTH(32), .REGISTER_WIDTH(5)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .dec_valid_i(dec_valid_i), .dec_is_mul_i(dec_is_mul_i),
      .dec_rs1_data_i(dec_rs1_data_i), .dec_rs2_data_i(dec_rs2_data_i),
      .dec_wr_reg_i(dec_wr_reg_i), .ex_bubble_i(ex_bubble_i), .stall_ex_i(stall_ex_i),
      .ex1_valid_o(ex1_valid_o), .ex2_valid_o(ex2_valid_o), .ex3_valid_o(ex3_valid_o),
      .ex4_valid_o(ex4_valid_o), .ex5_valid_o(ex5_valid_o),
      .ex1_wr_reg_o(ex1_wr_reg_o), .ex2_wr_reg_o(ex2_wr_reg_o), .ex3_wr_reg_o(ex3_wr_reg_o),
      .ex4_wr_reg_o(ex4_wr_reg_o), .ex5_wr_reg_o(ex5_wr_reg_o),
      .ex5_result_o(ex5_result_o), .ex5_wr_en_o(ex5_wr_en_o),
      .wb_is_next_cycle_o(wb_is_next_cycle_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] mul_lo(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = {32'd0, a} * {32'd0, b};
      return full[31:0];
   endfunction

   task automatic check_all();
      check_eq("ex1_valid", {31'd0, ex1_valid_o}, {31'd0, m_v[0]});
      check_eq("ex2_valid", {31'd0, ex2_valid_o}, {31'd0, m_v[1]});
      check_eq("ex3_valid", {31'd0, ex3_valid_o}, {31'd0, m_v[2]});
      check_eq("ex4_valid", {31'd0, ex4_valid_o}, {31'd0, m_v[3]});
      check_eq("ex5_valid", {31'd0, ex5_valid_o}, {31'd0, m_v[4]});
      check_eq("ex1_wr_reg", {27'd0, ex1_wr_reg_o}, {27'd0, m_w[0]});
      check_eq("ex2_wr_reg", {27'd0, ex2_wr_reg_o}, {27'd0, m_w[1]});
      check_eq("ex3_wr_reg", {27'd0, ex3_wr_reg_o}, {27'd0, m_w[2]});
      check_eq("ex4_wr_reg", {27'd0, ex4_wr_reg_o}, {27'd0, m_w[3]});
      check_eq("ex5_wr_reg", {27'd0, ex5_wr_reg_o}, {27'd0, m_w[4]});
      check_eq("ex5_result", ex5_result_o, m_p[4]);
      check_eq("ex5_wr_en", {31'd0, ex5_wr_en_o}, {31'd0, (m_v[4] && m_w[4] != 5'd0)});
      check_eq("wb_next", {31'd0, wb_is_next_cycle_o}, {31'd0, (m_v[3] && !stall_ex_i)});
   endtask

   task automatic model_edge();
      if (!rst_ni) begin
         for (int k = 0; k < 5; k++) begin
            m_v[k] = 1'b0; m_w[k] = 5'd0; m_p[k] = 32'd0;
         end
         m_a = 32'd0; m_b = 32'd0;
      end else if (!stall_ex_i) begin
         for (int k = 4; k > 0; k--) begin
            m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_p[k] = m_p[k-1];
         end
         m_v[0] = dec_valid_i && dec_is_mul_i && !ex_bubble_i;
         if (m_v[0]) begin
            m_a = dec_rs1_data_i; m_b = dec_rs2_data_i; m_w[0] = dec_wr_reg_i;
         end
         m_p[0] = mul_lo(m_a, m_b);
      end
   endtask

   // One cycle: drive at negedge, check #1 later, model the following posedge.
   task automatic cycle(input logic rstn, input logic v, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr, input logic bub,
                        input logic stl, input logic do_chk);
      rst_ni = rstn; dec_valid_i = v; dec_is_mul_i = m; dec_rs1_data_i = a;
      dec_rs2_data_i = b; dec_wr_reg_i = wr; ex_bubble_i = bub; stall_ex_i = stl;
      #1;
      if (do_chk) check_all();
      @(posedge clk_i);
      model_edge();
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] wr);
      cycle(1'b1, 1'b1, 1'b1, a, b, wr, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      @(negedge clk_i);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check_eq("rst_result", ex5_result_o, 32'd0);

      // single 7*6
      mul(32'd7, 32'd6, 5'd3);
      idle(4);
      check_eq("t1_result", ex5_result_o, 32'd42);
      check_eq("t1_wr_en", {31'd0, ex5_wr_en_o}, 32'd1);
      idle(1);
      check_eq("t1_wr_en_once", {31'd0, ex5_wr_en_o}, 32'd0);

      // back-to-back corner products
      mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      mul(32'h0001_0000, 32'h0001_0000, 5'd2);
      mul(32'h1234_5678, 32'h9ABC_DEF0, 5'd4);
      idle(2);
      check_eq("t2_r0", ex5_result_o, 32'h0000_0001);
      idle(1);
      check_eq("t2_r1", ex5_result_o, 32'h0000_0000);
      idle(1);
      check_eq("t2_r2", ex5_result_o, 32'h242D_2080);
      idle(2);

      // stall with MUL in EX3 for 3 cycles
      mul(32'd11, 32'd13, 5'd5);
      idle(2);
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, 1'b1, 32'd99, 32'd99, 5'd9, 1'b0, 1'b1, 1'b1);
      check_eq("t3_ex3_held", {31'd0, ex3_valid_o}, 32'd1);
      idle(2);
      check_eq("t3_result", ex5_result_o, 32'd143);

      // bubble blocks the accept, next accept proceeds; stall beats bubble
      cycle(1'b1, 1'b1, 1'b1, 32'd5, 32'd5, 5'd7, 1'b1, 1'b0, 1'b1);
      check_eq("t4_bubble", {31'd0, ex1_valid_o}, 32'd0);
      mul(32'd8, 32'd9, 5'd8);
      cycle(1'b1, 1'b1, 1'b1, 32'd5, 32'd5, 5'd7, 1'b1, 1'b1, 1'b1);
      idle(4);
      check_eq("t4_result", ex5_result_o, 32'd72);
      idle(1);

      // reset with three in flight
      mul(32'd2, 32'd3, 5'd1);
      mul(32'd4, 32'd5, 5'd2);
      mul(32'd6, 32'd7, 5'd3);
      cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      check_eq("t5_ex3_cleared", {31'd0, ex3_valid_o}, 32'd0);
      idle(6);
      check_eq("t5_no_wb", {31'd0, ex5_wr_en_o}, 32'd0);

      // wr_reg 0 still flows
      mul(32'd3, 32'd3, 5'd0);
      idle(3);
      check_eq("t6_wb_next", {31'd0, wb_is_next_cycle_o}, 32'd1);
      idle(1);
      check_eq("t6_result", ex5_result_o, 32'd9);
      check_eq("t6_valid", {31'd0, ex5_valid_o}, 32'd1);
      check_eq("t6_wr_en", {31'd0, ex5_wr_en_o}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(4) != 0),
               $urandom, $urandom, 5'($urandom_range(31)),
               ($urandom_range(7) == 0), ($urandom_range(4) == 0), 1'b1);
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
